// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared types and constants for the memory-mapped UART
//               transmitter: FSM state encoding, default bus addresses and
//               status-word bit positions.
//               Optional feature macro: UART_PARITY_EN (adds PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } uart_state_t;
`endif

    // Default bus addresses
    localparam logic [31:0] c_default_tx_addr     = 32'hFFFF_FF00;
    localparam logic [31:0] c_default_status_addr = 32'hFFFF_FF04;

    // Status word bit positions
    localparam int c_st_busy    = 0;
    localparam int c_st_full    = 1;
    localparam int c_st_empty   = 2;
    localparam int c_st_ovf     = 3;
    localparam int c_st_cnt_lsb = 4;
    localparam int c_st_cnt_msb = 8;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous byte FIFO with push, pop, full, empty and count.
//               A push while full is accepted only when a pop happens in the
//               same cycle, so the count stays unchanged in that case.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int               c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_full_count = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]    c_cnt_one    = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0]  c_ptr_one    = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full_count) || w_do_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped UART transmitter. Stores to TX_ADDR queue a
//               byte, stores to STATUS_ADDR with bit0 set clear the sticky
//               overflow flag. Bytes are serialized 8N1 (8E1 with parity)
//               on a registered, idle-high tx line.
//               Optional feature macro: UART_PARITY_EN (even parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = c_default_tx_addr,
    parameter logic [31:0] STATUS_ADDR  = c_default_status_addr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] status,
    output logic        tx,
    output logic        busy
);
    localparam int                    c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0]   c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0]   c_baud_one  = c_baud_w'(1);
    localparam int                    c_cnt_w     = $clog2(FIFO_DEPTH) + 1;

    uart_state_t         r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_ovf;
`ifdef UART_PARITY_EN
    logic                r_parity;
`endif

    logic                w_push;
    logic                w_clr;
    logic                w_pop;
    logic                w_baud_done;
    logic                w_ovf_set;
    logic [7:0]          w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic                w_unused_wdata;

    // Address decode of processor stores; loads have no side effects
    assign w_push         = memwrite && (dataadr == TX_ADDR);
    assign w_clr          = memwrite && (dataadr == STATUS_ADDR) && writedata[0];
    assign w_unused_wdata = ^writedata[31:8];

    assign w_baud_done = (r_baud == c_baud_last);

    // Pop from IDLE, or straight out of the last STOP cycle so frames abut
    assign w_pop = !w_fifo_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

    // A push to a full FIFO is dropped unless a pop frees a slot this cycle
    assign w_ovf_set = w_push && w_fifo_full && !w_pop;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (writedata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Sticky overflow flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Transmit FSM with baud counter, shift register and registered tx
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_bit_idx <= '0;
`ifdef UART_PARITY_EN
                r_parity  <= ^w_fifo_data;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud  <= r_baud + c_baud_one;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud  <= r_baud + c_baud_one;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE) || !w_fifo_empty;

    // Status word assembled from registered state only
    always_comb begin
        status                            = '0;
        status[c_st_busy]                 = busy;
        status[c_st_full]                 = w_fifo_full;
        status[c_st_empty]                = w_fifo_empty;
        status[c_st_ovf]                  = r_ovf;
        status[c_st_cnt_msb:c_st_cnt_lsb] = 5'(w_fifo_count);
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4,
//               FIFO_DEPTH=4). Expected bytes are queued at store time and a
//               serial-line monitor decodes and checks each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;
    localparam int          CPB  = 4;
    localparam logic [31:0] TXA  = 32'hFFFF_FF00;
    localparam logic [31:0] STA  = 32'hFFFF_FF04;
`ifdef UART_PARITY_EN
    localparam bit          PAR  = 1'b1;
    localparam int          NBIT = 11;
`else
    localparam bit          PAR  = 1'b0;
    localparam int          NBIT = 10;
`endif
    localparam int          FRAME_CYC = NBIT * CPB;

    typedef struct packed {
        logic [7:0] b;
        logic       btb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] status;
    logic        tx;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (TXA),
        .STATUS_ADDR  (STA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .status    (status),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected tx waveform, one entry per clock of the frame
    function automatic logic [43:0] exp_shape(input logic [7:0] b);
        logic [43:0] s;
        int          slot;
        s = '1;
        for (int i = 0; i < FRAME_CYC; i++) begin
            slot = i / CPB;
            if (slot == 0)                 s[i] = 1'b0;
            else if (slot <= 8)            s[i] = b[slot-1];
            else if (slot == 9 && PAR)     s[i] = ^b;
            else                           s[i] = 1'b1;
        end
        return s;
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    // Monitor: capture each frame on the serial line and compare to the scoreboard
    initial begin : monitor
        logic [43:0] shape;
        int          start_cyc;
        int          last_end;
        bit          aborted;
        exp_t        e;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                shape     = '1;
                shape[0]  = tx;
                start_cyc = cyc;
                aborted   = 1'b0;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    shape[i] = tx;
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_frame", {20'h0, shape}, 64'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("frame", {20'h0, shape}, {20'h0, exp_shape(e.b)});
                        if (e.btb) chk("frame_gap", start_cyc, last_end + 1);
                    end
                    last_end = cyc;
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        int n;
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        #1;
        chk("rst_tx", tx, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_status", status, 32'h4);
        chk("rst_busy", busy, 1'b0);

        // Single byte 0x55: latency and busy duration
        sb.push_back({8'h55, 1'b0});
        store(TXA, 32'h0000_0055);
        chk("lat_pre", tx, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 1) chk("lat_start", tx, 1'b0);
        end
        chk("busy_len", n, FRAME_CYC + 1);
        chk("idle_status", status, 32'h4);
        chk("idle_tx", tx, 1'b1);

        // Burst of five, then an overflowing sixth store
        sb.push_back({8'h01, 1'b0});
        sb.push_back({8'h02, 1'b1});
        sb.push_back({8'h03, 1'b1});
        sb.push_back({8'h04, 1'b1});
        sb.push_back({8'h05, 1'b1});
        store(TXA, 32'h01);
        store(TXA, 32'h02);
        store(TXA, 32'h03);
        store(TXA, 32'h04);
        store(TXA, 32'h05);
        chk("burst_status", status, 32'h43);
        store(TXA, 32'h06);
        chk("ovf_set", status, 32'h4B);
        store(STA, 32'hFFFF_FFFE);
        chk("ctl_bit0_clear", status, 32'h4B);
        store(STA, 32'h1);
        chk("ovf_clr", status, 32'h43);
        wait_idle("burst_done", 400);
        chk("burst_sb", sb.size(), 0);
        chk("burst_status_end", status, 32'h4);

        // Unmapped store and a status load: nothing happens
        store(32'hFFFF_FF08, 32'h77);
        chk("unmapped_status", status, 32'h4);
        dataadr = STA;
        @(negedge clk);
        chk("load_status", status, 32'h4);
        dataadr = 32'h0;
        repeat (20) @(negedge clk);
        chk("unmapped_tx", tx, 1'b1);

        // Upper store bits are ignored; 0x07 exercises the parity bit
        sb.push_back({8'hC3, 1'b0});
        store(TXA, 32'hABCD_12C3);
        wait_idle("c3_done", 100);
        sb.push_back({8'h07, 1'b0});
        store(TXA, 32'h07);
        wait_idle("p07_done", 100);
        chk("p07_sb", sb.size(), 0);

        // Reset in the middle of the data bits of 0xA3, with another byte queued
        store(TXA, 32'hA3);
        store(TXA, 32'h5A);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_status", status, 32'h4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_status", status, 32'h4);
        chk("final_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory bus of the 32-bit MIPS computer, downstream of the processor alongside `dmem`. It decodes processor stores (`memwrite`, `dataadr`, `writedata`) to two reserved addresses and queues bytes in a small FIFO. It serializes those bytes 8N1 on a single `tx` line. It also returns a status word that the top level muxes into `readdata` for loads from the status address.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, 2..16.
- `TX_ADDR`, 32'hFFFF_FF00: store address that enqueues a byte.
- `STATUS_ADDR`, 32'hFFFF_FF04: status read address; a store here is a control write.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  processor store strobe.
- `dataadr`  in  32  processor data address.
- `writedata`  in  32  processor store data.
- `status`  out  32  combinational status word; the top level selects it when `dataadr == STATUS_ADDR`.
- `tx`  out  1  serial output, registered, idle high.
- `busy`  out  1  high while a frame is in flight or the FIFO is non-empty.

## Operation
- Enqueue: `memwrite && dataadr == TX_ADDR` pushes `writedata[7:0]`. Bits [31:8] are ignored.
- Push while full is dropped and sets sticky `overflow`.
- Exception: push while full in the same cycle as an FSM pop is accepted, and the count is unchanged.
- Control: `memwrite && dataadr == STATUS_ADDR && writedata[0]` clears `overflow`. Other bits are ignored.
- If a clear and an overflowing push occur in the same cycle, the set wins.
- Status word: bit0 `busy`, bit1 fifo full, bit2 fifo empty, bit3 `overflow`, bits[8:4] FIFO count (0..16), remaining bits 0.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register, clear the bit index, and go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send 8 bits LSB first, each for `CLKS_PER_BIT` cycles. After bit 7, go to PARITY or STOP.
- STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- A non-empty FIFO is re-popped on the next cycle, so back-to-back frames have no extra idle gap.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and resets on every state or bit change. Its width is `$clog2(CLKS_PER_BIT)`.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits wide.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `status` = 32'h0000_0004 (empty), FSM in IDLE, FIFO emptied, `overflow` = 0.
- Reset asserted mid-frame aborts the frame immediately and forces `tx` high asynchronously. Queued bytes are lost.
- Latency: store captured at edge N; FSM pops at edge N+1; `tx` falls after edge N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- `status` and `busy` reflect registered state and change only after clock edges. No combinational path exists from `writedata` to `tx`.
- A load from `STATUS_ADDR` has no side effects.

## Configuration
- `UART_PARITY_EN` defined: a PARITY state between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- `UART_PARITY_EN` undefined: the PARITY state and its logic are absent; frames are 8N1.
- The status layout is identical in both builds.

## Structure
- Package `mmio_pkg` holds:
  - the `uart_state_t` enum;
  - default `TX_ADDR` and `STATUS_ADDR` constants;
  - status bit-position constants.
- Sub-module `uart_fifo`: synchronous FIFO with push, pop, full, empty and count, parameterized by depth and width 8.
- Top-level FSM, baud counter, shift register and address decode live in `mmio_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
- Store 32'h0000_0055 to `TX_ADDR`: `tx` low 4 cycles from edge N+1, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. `busy` drops after the stop bit.
- Five stores 0x01..0x05 on consecutive cycles:
  - first byte popped immediately, next four queued, none dropped, `overflow` = 0;
  - a sixth store before the next pop sets status bit3;
  - output frames are 0x01..0x05 back to back with no gap.
- Overflow clear: store 1 to `STATUS_ADDR` when `overflow` = 1; status bit3 reads 0 next cycle.
- Assert reset mid-DATA of byte 0xA3: `tx` goes 1 immediately, `status` = 32'h4, and no further frames follow.
- Store to 32'hFFFF_FF08 and a load from `STATUS_ADDR`: no enqueue, no state change.
- With `UART_PARITY_EN`, send 0x07: the parity bit equals 1 and the frame lasts 44 cycles.
